// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [3:0]       sel_q;
  logic             grant_id, last_grant, zero_q, err_q;
  logic             grant, accept, sel_legal, rsp_fire;

  // Tie goes to the requester not served last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign sel_legal = (sel_q == 4'b0000) || (sel_q == 4'b0001) ||
                     (sel_q == 4'b0010) || (sel_q == 4'b0110);

  assign rsp_fire = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 4'b0000;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant_id <= grant;
        a_q      <= grant ? req1_a   : req0_a;
        b_q      <= grant ? req1_b   : req0_b;
        sel_q    <= grant ? req1_sel : req0_sel;
      end
      if (state == EXEC) begin
        result_q <= sel_legal ? alu_out  : '0;
        zero_q   <= sel_legal ? alu_zero : 1'b1;
        err_q    <= !sel_legal;
      end
      if (rsp_fire) last_grant <= grant_id;
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;

  // Only the granted port sees the response; the other reads all zeros.
  assign rsp0_valid  = (state == RESP) && !grant_id;
  assign rsp1_valid  = (state == RESP) && grant_id;
  assign rsp0_result = rsp0_valid ? result_q : '0;
  assign rsp0_zero   = rsp0_valid && zero_q;
  assign rsp0_err    = rsp0_valid && err_q;
  assign rsp1_result = rsp1_valid ? result_q : '0;
  assign rsp1_zero   = rsp1_valid && zero_q;
  assign rsp1_err    = rsp1_valid && err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel, alu_sel;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference ALU; illegal selects produce garbage the arbiter must mask.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    rst_n = 1'b0;
    step();
    checks++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin failures++; $display("FAIL reset_handshake got=%b exp=0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 68'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_sel}); end
    checks++; if ({rsp0_result, rsp0_zero, rsp0_err, rsp1_result, rsp1_zero, rsp1_err} !== 68'h0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp0_result, rsp0_zero, rsp0_err, rsp1_result, rsp1_zero, rsp1_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_sel = 4'b0010;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_exec_valid got=%b%b exp=00", rsp0_valid, rsp1_valid); end
    checks++; if ({alu_a, alu_b, alu_sel} !== {32'd5, 32'd7, 4'b0010}) begin failures++; $display("FAIL single_alu_drive got=%h exp=%h", {alu_a, alu_b, alu_sel}, {32'd5, 32'd7, 4'b0010}); end
    step();
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin failures++; $display("FAIL single_rsp_valid got=%b exp=10", {rsp0_valid, rsp1_valid}); end
    checks++; if ({rsp0_result, rsp0_zero, rsp0_err} !== {32'd12, 1'b0, 1'b0}) begin failures++; $display("FAIL single_rsp got=%h exp=%h", {rsp0_result, rsp0_zero, rsp0_err}, {32'd12, 2'b00}); end
    checks++; if (rsp1_result !== 32'h0) begin failures++; $display("FAIL single_other_port got=%h exp=0", rsp1_result); end
    @(negedge clk);
    rsp0_ready = 1;
    #1;
    step();
    checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_done got=%b exp=0", rsp0_valid); end
    rsp0_ready = 0;
  endtask

  task automatic test_contention();
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_sel = 4'b0110;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_sel = 4'b0001;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL cont_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL cont_no_accept_exec got=%b exp=0", req1_ready); end
    step();
    checks++; if ({rsp0_valid, rsp0_result, rsp0_zero} !== {1'b1, 32'd0, 1'b1}) begin failures++; $display("FAIL cont_sub got=%h exp=%h", {rsp0_valid, rsp0_result, rsp0_zero}, {1'b1, 32'd0, 1'b1}); end
    step();
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL cont_loser_served got=%b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    step();
    checks++; if ({rsp1_valid, rsp1_result, rsp1_zero, rsp0_valid} !== {1'b1, 32'hFF, 1'b0, 1'b0}) begin failures++; $display("FAIL cont_or got=%h exp=%h", {rsp1_valid, rsp1_result, rsp1_zero, rsp0_valid}, {1'b1, 32'hFF, 2'b00}); end
    // last_grant=1 now: a fresh pair goes to req0, then the next pair to req1
    @(negedge clk);
    req0_valid = 1; req0_a = 32'hFF; req0_b = 32'h0F; req0_sel = 4'b0000;
    req1_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL cont_pair2 got=%b exp=10", {req0_ready, req1_ready}); end
    step();
    step();
    checks++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'h0F}) begin failures++; $display("FAIL cont_pair2_rsp got=%h exp=%h", {rsp0_valid, rsp0_result}, {1'b1, 32'h0F}); end
    step();
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL cont_pair3 got=%b exp=01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    step();
    checks++; if ({rsp1_valid, rsp1_result} !== {1'b1, 32'hFF}) begin failures++; $display("FAIL cont_pair3_rsp got=%h exp=%h", {rsp1_valid, rsp1_result}, {1'b1, 32'hFF}); end
    step();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_wrap_backpressure();
    @(negedge clk);
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_sel = 4'b0010;
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL wrap_accept got=%b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_a = 32'h1234; req0_b = 32'hFF; req0_sel = 4'b0000;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin failures++; $display("FAIL wrap_hold%0d got=%h exp=%h", i, {rsp1_valid, rsp1_result, rsp1_zero, rsp1_err}, {1'b1, 32'h0, 2'b10}); end
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL wrap_block%0d got=%b exp=0", i, req0_ready); end
    end
    @(negedge clk);
    rsp1_ready = 1;
    #1;
    step();
    checks++; if ({req0_ready, rsp1_valid} !== 2'b10) begin failures++; $display("FAIL wrap_release got=%b exp=10", {req0_ready, rsp1_valid}); end
    rsp1_ready = 0;
    @(negedge clk);
    req0_valid = 0; rsp0_ready = 1;
    step();
    checks++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'h34}) begin failures++; $display("FAIL wrap_req0_rsp got=%h exp=%h", {rsp0_valid, rsp0_result}, {1'b1, 32'h34}); end
    step();
    rsp0_ready = 0;
  endtask

  task automatic test_illegal_sel();
    rsp0_ready = 1;
    @(negedge clk);
    req0_valid = 1; req0_a = 3; req0_b = 3; req0_sel = 4'b0111;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL illegal_accept got=%b exp=1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    step();
    checks++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin failures++; $display("FAIL illegal_rsp got=%h exp=%h", {rsp0_valid, rsp0_result, rsp0_zero, rsp0_err}, {1'b1, 32'h0, 2'b11}); end
    @(negedge clk);
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_sel = 4'b0010;
    #1;
    checks++; if ({req0_ready, rsp0_valid} !== 2'b10) begin failures++; $display("FAIL illegal_back_idle got=%b exp=10", {req0_ready, rsp0_valid}); end
    @(negedge clk);
    req0_valid = 0;
    step();
    checks++; if ({rsp0_result, rsp0_zero, rsp0_err} !== {32'd4, 2'b00}) begin failures++; $display("FAIL illegal_err_clear got=%h exp=%h", {rsp0_result, rsp0_zero, rsp0_err}, {32'd4, 2'b00}); end
    step();
    rsp0_ready = 0;
  endtask

  task automatic test_reset_midop();
    rsp1_ready = 1;
    @(negedge clk);
    req1_valid = 1; req1_a = 32'hF0F0; req1_b = 32'hFF00; req1_sel = 4'b0000;
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL midop_accept got=%b exp=1", req1_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({alu_a, alu_b, alu_sel, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 72'h0) begin failures++; $display("FAIL midop_reset_outputs got=%h exp=0", {alu_a, alu_b, alu_sel, req0_ready, req1_ready, rsp0_valid, rsp1_valid}); end
    step();
    checks++; if (rsp1_valid !== 1'b0) begin failures++; $display("FAIL midop_no_rsp got=%b exp=0", rsp1_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL midop_reaccept got=%b exp=01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 0;
    step();
    checks++; if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, 32'hF000, 2'b00}) begin failures++; $display("FAIL midop_and got=%h exp=%h", {rsp1_valid, rsp1_result, rsp1_zero, rsp1_err}, {1'b1, 32'hF000, 2'b00}); end
    step();
    rsp1_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_wrap_backpressure();
    test_illegal_sel();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
